// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS sequencer: state encoding, opcode map, flag index.
package picomips_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MULW   = 3'd3,
        INW    = 3'd4,
        WB     = 3'd5
    } seq_state_t;

    typedef logic [2:0] opcode_t;

    // Opcode map mirrors IR[15:13]; codes 6 and 7 are unimplemented.
    localparam opcode_t OP_NOP  = 3'd0;
    localparam opcode_t OP_ADD  = 3'd1;
    localparam opcode_t OP_MULI = 3'd2;
    localparam opcode_t OP_BEQ  = 3'd3;
    localparam opcode_t OP_BNE  = 3'd4;
    localparam opcode_t OP_LWD  = 3'd5;

    localparam int Z_BIT = 0;

endpackage

// File: rtl/picomips_seq_timer.sv
// MULW wait counter: cleared on multiply launch, counts idle wait cycles, flags the last allowed one.
module picomips_seq_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [W-1:0] r_count;

    assign o_expired = (r_count == W'(MAX_WAIT - 1));

    // Wait counter; saturates at the expiry value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/picomips_seq_ctrl.sv
// picoMIPS multi-cycle sequencer (FETCH/DECODE/EXEC/MULW/INW/WB) emitting per-phase enables.
// Optional retired-instruction counter enabled by macro PICOMIPS_SEQ_PERF_EN.
module picomips_seq_ctrl
    import picomips_pkg::*;
#(
    parameter int MUL_MAX_WAIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hold,
    input  logic [2:0]       i_opcode,
    input  logic [1:0]       i_flags,
    input  logic             i_mul_done,
    input  logic             i_in_valid,
    output logic             o_ir_en,
    output logic             o_pc_en,
    output logic             o_pc_rel,
    output logic             o_rf_we,
    output logic             o_mul_start,
    output logic             o_in_ack,
    output logic             o_err_illegal,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_instr_count
);
    seq_state_t r_state;
    seq_state_t w_next;
    opcode_t    r_opcode;
    logic       r_err_illegal;
    logic       r_err_timeout;

    logic w_ir_en, w_pc_en, w_pc_rel, w_rf_we, w_mul_start, w_in_ack;
    logic w_set_illegal, w_set_timeout;
    logic w_active;
    logic w_expired;
    logic w_unused;

    // Only the Z flag steers branches.
    assign w_unused = ^{i_flags[1]};
    assign w_active = !i_hold && !i_reset;

    picomips_seq_timer #(.MAX_WAIT(MUL_MAX_WAIT)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_active && (r_state == EXEC)),
        .i_en      (w_active && (r_state == MULW) && !i_mul_done),
        .o_expired (w_expired)
    );

    // State register, opcode latch and sticky error bits; hold freezes everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= FETCH;
            r_opcode      <= OP_NOP;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else if (!i_hold) begin
            r_state       <= w_next;
            r_opcode      <= (r_state == DECODE) ? i_opcode : r_opcode;
            r_err_illegal <= r_err_illegal | w_set_illegal;
            r_err_timeout <= r_err_timeout | w_set_timeout;
        end else begin
            r_state       <= r_state;
            r_opcode      <= r_opcode;
            r_err_illegal <= r_err_illegal;
            r_err_timeout <= r_err_timeout;
        end
    end

    // Next-state and per-phase strobe decode.
    always_comb begin
        w_next        = r_state;
        w_ir_en       = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_rel      = 1'b0;
        w_rf_we       = 1'b0;
        w_mul_start   = 1'b0;
        w_in_ack      = 1'b0;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            FETCH: begin
                w_ir_en = 1'b1;
                w_next  = DECODE;
            end
            DECODE: w_next = EXEC;
            EXEC: begin
                case (r_opcode)
                    OP_NOP: begin
                        w_pc_en = 1'b1;
                        w_next  = FETCH;
                    end
                    OP_BEQ: begin
                        w_pc_en  = 1'b1;
                        w_pc_rel = i_flags[Z_BIT];
                        w_next   = FETCH;
                    end
                    OP_BNE: begin
                        w_pc_en  = 1'b1;
                        w_pc_rel = !i_flags[Z_BIT];
                        w_next   = FETCH;
                    end
                    OP_ADD:  w_next = WB;
                    OP_MULI: begin
                        w_mul_start = 1'b1;
                        w_next      = MULW;
                    end
                    OP_LWD:  w_next = INW;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_pc_en       = 1'b1;
                        w_next        = FETCH;
                    end
                endcase
            end
            MULW: begin
                if (i_mul_done) begin
                    w_next = WB;
                end else if (w_expired) begin
                    // Abort still retires the instruction, without a register write.
                    w_set_timeout = 1'b1;
                    w_pc_en       = 1'b1;
                    w_next        = FETCH;
                end else begin
                    w_next = MULW;
                end
            end
            INW: begin
                if (i_in_valid) begin
                    w_next = WB;
                end else begin
                    w_next = INW;
                end
            end
            WB: begin
                w_rf_we  = 1'b1;
                w_pc_en  = 1'b1;
                w_in_ack = (r_opcode == OP_LWD);
                w_next   = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    assign o_ir_en       = w_ir_en     & w_active;
    assign o_pc_en       = w_pc_en     & w_active;
    assign o_pc_rel      = w_pc_rel    & w_active;
    assign o_rf_we       = w_rf_we     & w_active;
    assign o_mul_start   = w_mul_start & w_active;
    assign o_in_ack      = w_in_ack    & w_active;
    assign o_err_illegal = r_err_illegal;
    assign o_err_timeout = r_err_timeout;

`ifdef PICOMIPS_SEQ_PERF_EN
    logic [CNT_W-1:0] r_instr_count;

    // Retired-instruction counter; wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr_count <= '0;
        end else if (o_pc_en) begin
            r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign o_instr_count = r_instr_count;
`else
    assign o_instr_count = '0;
`endif

endmodule

// File: tb/tb_picomips_seq_ctrl.sv
// Self-checking bench for picomips_seq_ctrl: directed phase tests, hold/reset cases, random instruction stream.
module tb_picomips_seq_ctrl;
    import picomips_pkg::*;

    localparam logic [5:0] S_IR  = 6'b100000;
    localparam logic [5:0] S_PC  = 6'b010000;
    localparam logic [5:0] S_REL = 6'b001000;
    localparam logic [5:0] S_WE  = 6'b000100;
    localparam logic [5:0] S_MS  = 6'b000010;
    localparam logic [5:0] S_ACK = 6'b000001;
    localparam logic [5:0] S_0   = 6'b000000;

    logic        clk = 1'b0;
    logic        i_reset, i_hold, i_mul_done, i_in_valid;
    logic [2:0]  i_opcode;
    logic [1:0]  i_flags;
    logic        o_ir_en, o_pc_en, o_pc_rel, o_rf_we, o_mul_start, o_in_ack;
    logic        o_err_illegal, o_err_timeout;
    logic [15:0] o_instr_count;
    logic [5:0]  strobes;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_retired = 0;
    logic        m_ill = 1'b0;
    logic        m_to  = 1'b0;

    always #5 clk = ~clk;

    assign strobes = {o_ir_en, o_pc_en, o_pc_rel, o_rf_we, o_mul_start, o_in_ack};

    picomips_seq_ctrl #(.MUL_MAX_WAIT(16), .CNT_W(16)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_hold        (i_hold),
        .i_opcode      (i_opcode),
        .i_flags       (i_flags),
        .i_mul_done    (i_mul_done),
        .i_in_valid    (i_in_valid),
        .o_ir_en       (o_ir_en),
        .o_pc_en       (o_pc_en),
        .o_pc_rel      (o_pc_rel),
        .o_rf_we       (o_rf_we),
        .o_mul_start   (o_mul_start),
        .o_in_ack      (o_in_ack),
        .o_err_illegal (o_err_illegal),
        .o_err_timeout (o_err_timeout),
        .o_instr_count (o_instr_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: compare strobes mid-cycle, then advance past the next rising edge.
    task automatic cyc(input logic [5:0] exp, input string tag);
        @(negedge clk);
        check_val(tag, {26'd0, strobes}, {26'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_val({tag, "_err_illegal"}, {31'd0, o_err_illegal}, {31'd0, m_ill});
        check_val({tag, "_err_timeout"}, {31'd0, o_err_timeout}, {31'd0, m_to});
`ifdef PICOMIPS_SEQ_PERF_EN
        check_val({tag, "_instr_count"}, {16'd0, o_instr_count}, m_retired & 32'h0000FFFF);
`else
        check_val({tag, "_instr_count"}, {16'd0, o_instr_count}, 32'd0);
`endif
    endtask

    // Expected cycle sequence of one instruction; d = cycles the multiplier / input port stays not-ready.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] fl, input int d);
        logic take;
        i_opcode   = 3'($urandom);
        i_flags    = fl;
        i_mul_done = 1'b0;
        i_in_valid = 1'b0;
        cyc(S_IR, "fetch");
        i_opcode = op;
        cyc(S_0, "decode");
        i_opcode = 3'($urandom);
        case (op)
            OP_ADD: begin
                cyc(S_0, "add_exec");
                cyc(S_WE | S_PC, "add_wb");
            end
            OP_BEQ, OP_BNE: begin
                take = (op == OP_BEQ) ? fl[0] : !fl[0];
                cyc(take ? (S_PC | S_REL) : S_PC, "branch_exec");
            end
            OP_MULI: begin
                cyc(S_MS, "muli_exec");
                if (d < 16) begin
                    for (int k = 0; k < d; k++) cyc(S_0, "mulw_wait");
                    i_mul_done = 1'b1;
                    cyc(S_0, "mulw_done");
                    cyc(S_WE | S_PC, "muli_wb");
                end else begin
                    for (int k = 0; k < 15; k++) cyc(S_0, "mulw_wait");
                    cyc(S_PC, "mulw_abort");
                    m_to = 1'b1;
                end
            end
            OP_LWD: begin
                cyc(S_0, "lwd_exec");
                for (int k = 0; k < d; k++) cyc(S_0, "inw_wait");
                i_in_valid = 1'b1;
                cyc(S_0, "inw_seen");
                cyc(S_WE | S_PC | S_ACK, "lwd_wb");
                i_in_valid = 1'b0;
            end
            OP_NOP: cyc(S_PC, "nop_exec");
            default: begin
                cyc(S_PC, "illegal_exec");
                m_ill = 1'b1;
            end
        endcase
        m_retired++;
        check_model("instr");
    endtask

    initial begin
        logic [2:0] op;
        i_reset    = 1'b1;
        i_hold     = 1'b0;
        i_opcode   = 3'd0;
        i_flags    = 2'b00;
        i_mul_done = 1'b0;
        i_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(S_0, "reset_strobes");
        check_model("reset");
        i_reset = 1'b0;

        run_instr(OP_ADD,  2'b00, 0);
        run_instr(OP_NOP,  2'b00, 0);
        run_instr(OP_BEQ,  2'b01, 0);
        run_instr(OP_BEQ,  2'b00, 0);
        run_instr(OP_BNE,  2'b01, 0);
        run_instr(OP_BNE,  2'b10, 0);
        run_instr(OP_MULI, 2'b00, 3);
        run_instr(OP_MULI, 2'b00, 0);
        run_instr(OP_MULI, 2'b00, 15);
        run_instr(OP_MULI, 2'b00, 16);
        run_instr(OP_LWD,  2'b00, 10);
        run_instr(3'd6,    2'b00, 0);

        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom);
            run_instr(op, 2'($urandom), (op == OP_MULI) ? int'($urandom_range(0, 20))
                                                        : int'($urandom_range(0, 12)));
        end

        // Hold mid-MULW with mul_done already up: nothing moves, result not lost.
        i_opcode   = OP_MULI;
        i_mul_done = 1'b0;
        cyc(S_IR, "h_fetch");
        cyc(S_0, "h_decode");
        cyc(S_MS, "h_exec");
        cyc(S_0, "h_mulw0");
        cyc(S_0, "h_mulw1");
        i_hold     = 1'b1;
        i_mul_done = 1'b1;
        for (int k = 0; k < 5; k++) cyc(S_0, "hold_strobes");
        check_model("hold");
        i_hold = 1'b0;
        cyc(S_0, "h_mulw_done");
        cyc(S_WE | S_PC, "h_wb");
        m_retired++;
        check_model("after_hold");

        // Reset while parked in INW with input valid: no write, no ack, back to FETCH.
        i_mul_done = 1'b0;
        i_opcode   = OP_LWD;
        cyc(S_IR, "r_fetch");
        cyc(S_0, "r_decode");
        cyc(S_0, "r_exec");
        cyc(S_0, "r_inw");
        i_in_valid = 1'b1;
        i_reset    = 1'b1;
        cyc(S_0, "reset_in_inw");
        cyc(S_0, "reset_in_inw2");
        i_reset    = 1'b0;
        i_in_valid = 1'b0;
        m_ill      = 1'b0;
        m_to       = 1'b0;
        m_retired  = 0;
        check_model("after_reset");
        run_instr(OP_NOP, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
